demux_1_to_2: RTL and testbench

- Registered 1-to-2 stream demultiplexer, the inverse of the 2-to-1 select path.
- Steers each accepted input word to output A or B according to a per-word key.
- Buffers words in a per-output FIFO, so each output can stall independently.
- Placed between a single producer and two consumers; valid/ready handshake on all three ports.

---
 rtl/demux_1_to_2_if.sv | 31 +++
 rtl/demux_1_to_2.sv | 110 +++++++++++
 tb/tb_demux_1_to_2.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/demux_1_to_2_if.sv
// Stream bundle for the 1-to-2 demux: one keyed producer port and two consumer ports.
// The demux takes the slave side; a producer/consumer model takes the master side.
interface demux_1_to_2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                  i_key;
  logic [DATA_WIDTH-1:0] i_val;
  logic                  i_vld;
  logic                  o_rdy;
  logic [DATA_WIDTH-1:0] o_val_a;
  logic                  o_vld_a;
  logic                  i_rdy_a;
  logic [DATA_WIDTH-1:0] o_val_b;
  logic                  o_vld_b;
  logic                  i_rdy_b;
  logic [CNT_WIDTH-1:0]  o_cnt_a;
  logic [CNT_WIDTH-1:0]  o_cnt_b;

  modport slave (
    input  i_key, i_val, i_vld, i_rdy_a, i_rdy_b,
    output o_rdy, o_val_a, o_vld_a, o_val_b, o_vld_b, o_cnt_a, o_cnt_b
  );

  modport master (
    output i_key, i_val, i_vld, i_rdy_a, i_rdy_b,
    input  o_rdy, o_val_a, o_vld_a, o_val_b, o_vld_b, o_cnt_a, o_cnt_b
  );
endinterface

// File: rtl/demux_1_to_2.sv
// Registered 1-to-2 demux: each word lands in a per-output FIFO, visible the cycle after accept.
// Backpressure: o_rdy drops only when the keyed FIFO is full; each output stalls independently.
module demux_1_to_2_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_dat_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_dat_o,
  output logic                  head_vld_o,
  output logic                  full_o,
  output logic [CNT_WIDTH-1:0]  cnt_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  push_en;
  logic                  pop_en;

  assign head_vld_o = (cnt_q != '0);
  assign full_o     = (cnt_q == CNT_WIDTH'(DEPTH));
  assign cnt_o      = cnt_q;
  // Empty FIFOs present zero rather than stale storage.
  assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && head_vld_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_en && !pop_en) cnt_d = cnt_q + CNT_WIDTH'(1);
    if (pop_en && !push_en) cnt_d = cnt_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en && !rst_i) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module demux_1_to_2 #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  demux_1_to_2_if.slave  bus
);
  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;

  // Ready looks only at the keyed FIFO's registered fill; no full-pass-through on same-cycle pop.
  assign bus.o_rdy = bus.i_key ? !full_b : !full_a;
  assign push_a    = bus.i_vld && bus.o_rdy && !bus.i_key;
  assign push_b    = bus.i_vld && bus.o_rdy &&  bus.i_key;

  demux_1_to_2_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo_a (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .push_i     (push_a),
    .push_dat_i (bus.i_val),
    .pop_i      (bus.i_rdy_a),
    .head_dat_o (bus.o_val_a),
    .head_vld_o (bus.o_vld_a),
    .full_o     (full_a),
    .cnt_o      (bus.o_cnt_a)
  );

  demux_1_to_2_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo_b (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .push_i     (push_b),
    .push_dat_i (bus.i_val),
    .pop_i      (bus.i_rdy_b),
    .head_dat_o (bus.o_val_b),
    .head_vld_o (bus.o_vld_b),
    .full_o     (full_b),
    .cnt_o      (bus.o_cnt_b)
  );
endmodule

// File: tb/tb_demux_1_to_2.sv
// Bench for demux_1_to_2: directed scenarios plus random traffic, checked against
// two plain word queues that model the per-output FIFOs.
module tb_demux_1_to_2;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_1_to_2_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  demux_1_to_2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit            last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check outputs against the queues, then advance the model at posedge.
  task automatic cycle(input bit r, input bit vld, input bit key, input logic [DW-1:0] val,
                       input bit ra, input bit rb);
    bit exp_rdy, pa, pb, acc;
    @(negedge clk);
    rst = r; bus.i_vld = vld; bus.i_key = key; bus.i_val = val;
    bus.i_rdy_a = ra; bus.i_rdy_b = rb;
    #1;
    exp_rdy = key ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    chk("o_rdy",   64'(bus.o_rdy),   64'(exp_rdy));
    chk("o_vld_a", 64'(bus.o_vld_a), 64'(qa.size() != 0));
    chk("o_vld_b", 64'(bus.o_vld_b), 64'(qb.size() != 0));
    chk("o_val_a", 64'(bus.o_val_a), (qa.size() != 0) ? 64'(qa[0]) : 64'd0);
    chk("o_val_b", 64'(bus.o_val_b), (qb.size() != 0) ? 64'(qb[0]) : 64'd0);
    chk("o_cnt_a", 64'(bus.o_cnt_a), 64'(qa.size()));
    chk("o_cnt_b", 64'(bus.o_cnt_b), 64'(qb.size()));
    pa  = !r && ra && (qa.size() != 0);
    pb  = !r && rb && (qb.size() != 0);
    acc = !r && vld && exp_rdy;
    @(posedge clk);
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (acc && !key) qa.push_back(val);
      if (acc &&  key) qb.push_back(val);
    end
    last_acc = acc;
  endtask

  initial begin
    bit            cv, ck;
    logic [DW-1:0] cval;

    bus.i_vld = 1'b1; bus.i_key = 1'b0; bus.i_val = 32'hDEAD_BEEF;
    bus.i_rdy_a = 1'b0; bus.i_rdy_b = 1'b0;

    // Reset held with a valid word presented: nothing may be written.
    @(posedge clk);
    cycle(1, 1, 0, 32'hDEAD_BEEF, 0, 0);
    cycle(1, 1, 1, 32'hBEEF_DEAD, 0, 0);
    #1;
    chk("rst_cnt_a", 64'(bus.o_cnt_a), 64'd0);
    chk("rst_vld_b", 64'(bus.o_vld_b), 64'd0);
    chk("rst_val_a", 64'(bus.o_val_a), 64'd0);
    cycle(0, 0, 0, 32'h0, 1, 1);

    // Basic steer, each word valid for exactly one cycle.
    cycle(0, 1, 0, 32'h11, 1, 1);
    #1 chk("steer_a", 64'(bus.o_val_a), 64'h11);
    cycle(0, 1, 1, 32'h22, 1, 1);
    #1 chk("steer_b", 64'(bus.o_val_b), 64'h22);
    chk("steer_a_gone", 64'(bus.o_vld_a), 64'd0);
    cycle(0, 0, 0, 32'h0, 1, 1);
    #1 chk("steer_b_gone", 64'(bus.o_vld_b), 64'd0);

    // Fill A, hold 0xA2 blocked, slip a key1 word past it, then drain.
    cycle(0, 1, 0, 32'hA0, 0, 0);
    cycle(0, 1, 0, 32'hA1, 0, 0);
    cycle(0, 1, 0, 32'hA2, 0, 0);
    chk("fill_cnt_a", 64'(bus.o_cnt_a), 64'd2);
    chk("fill_blocked", 64'(last_acc), 64'd0);
    cycle(0, 1, 1, 32'hB5, 0, 0);
    chk("other_accepted", 64'(last_acc), 64'd1);
    cycle(0, 1, 0, 32'hA2, 1, 1);
    chk("full_pop_no_accept", 64'(last_acc), 64'd0);
    cycle(0, 1, 0, 32'hA2, 1, 1);
    chk("a2_accepted", 64'(last_acc), 64'd1);
    repeat (3) cycle(0, 0, 0, 32'h0, 1, 1);

    // Concurrent push/pop at count 1 across pointer wrap.
    cycle(0, 1, 0, 32'h01, 0, 0);
    for (int i = 2; i <= 9; i++) begin
      cycle(0, 1, 0, DW'(i), 1, 0);
      #1 chk("pp_cnt_a", 64'(bus.o_cnt_a), 64'd1);
    end
    cycle(0, 0, 0, 32'h0, 1, 0);

    // Full + pop in the same cycle: 2 -> 1 -> 2.
    cycle(0, 1, 0, 32'hC0, 0, 0);
    cycle(0, 1, 0, 32'hC1, 0, 0);
    cycle(0, 1, 0, 32'hC2, 1, 0);
    #1 chk("fp_cnt_1", 64'(bus.o_cnt_a), 64'd1);
    cycle(0, 1, 0, 32'hC2, 0, 0);
    #1 chk("fp_cnt_2", 64'(bus.o_cnt_a), 64'd2);

    // Mid-stream reset with both FIFOs full.
    cycle(0, 1, 1, 32'hD0, 0, 0);
    cycle(0, 1, 1, 32'hD1, 0, 0);
    cycle(1, 1, 0, 32'hE0, 1, 1);
    #1 chk("mid_rst_cnt_a", 64'(bus.o_cnt_a), 64'd0);
    chk("mid_rst_cnt_b", 64'(bus.o_cnt_b), 64'd0);
    repeat (3) cycle(0, 0, 0, 32'h0, 1, 1);

    // Random traffic; the producer holds a word until it is accepted.
    cv = 1'b0; ck = 1'b0; cval = '0; last_acc = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (last_acc || !cv) begin
        cv   = ($urandom_range(0, 3) != 0);
        ck   = 1'($urandom_range(0, 1));
        cval = $urandom;
      end
      cycle(($urandom_range(0, 99) == 0), cv, ck, cval,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
    end
    repeat (4) cycle(0, 0, 0, 32'h0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
